tow_referee: RTL and testbench

TOW_REFEREE -- requirements
Module: tow_referee

---
 rtl/tow_pkg.sv | 24 ++
 rtl/tow_holdoff.sv | 26 ++
 rtl/tow_referee.sv | 131 +++++++++++++
 tb/tb_tow_referee.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war referee.
// Rope position runs 0..6 with the centre at 3; one LED per position.
package tow_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    HOLD = S_HOLD,
    WIN  = S_WIN
  } tow_state_e;

  localparam logic [2:0] POS_MIN    = 3'd0;
  localparam logic [2:0] POS_CENTER = 3'd3;
  localparam logic [2:0] POS_MAX    = 3'd6;
  localparam int         LED_W      = 7;

  function automatic logic [LED_W-1:0] pos_leds(input logic [2:0] p);
    return {{(LED_W-1){1'b0}}, 1'b1} << p;
  endfunction

endpackage

// File: rtl/tow_holdoff.sv
// Holdoff down-counter: load starts a count of holdoff-1 cycles, done while at zero.
// Latency: done drops the cycle after load and rises again holdoff-1 cycles later.
// Backpressure: none; load always wins over the running count.
module tow_holdoff (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] holdoff,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= holdoff - 8'd1;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/tow_referee.sv
// Tug-of-war referee: moves the rope on latched presses, declares winners, keeps scores.
// Latency: one edge from accepted press to new position and clear pulse.
// Backpressure: presses ignored during holdoff and in WIN; TOW_REFEREE_SCORE_EN enables scoring.
module tow_referee
  import tow_pkg::*;
#(
  parameter int HOLDOFF = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             tie,
  input  logic             right,
  input  logic             new_game,
  output logic             clear,
  output logic [LED_W-1:0] leds,
  output logic             win_l,
  output logic             win_r,
  output logic [3:0]       score_l,
  output logic [3:0]       score_r
);

  logic [1:0] state;
  logic [2:0] pos;
  logic [2:0] next_pos;
  logic       hold_done;
  logic       hold_load;
  logic       take_push;

  assign take_push = (state == S_IDLE) && push && !new_game;
  assign hold_load = new_game || take_push;

  // Position only changes from 1..5, so neither step can wrap.
  always_comb begin
    next_pos = pos;
    if (!tie) begin
      next_pos = right ? pos + 3'd1 : pos - 3'd1;
    end
  end

  tow_holdoff u_holdoff (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .holdoff (8'(HOLDOFF)),
    .done    (hold_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      pos   <= POS_CENTER;
      clear <= 1'b0;
      win_l <= 1'b0;
      win_r <= 1'b0;
    end else begin
      clear <= 1'b0;
      if (new_game) begin
        state <= S_HOLD;
        pos   <= POS_CENTER;
        win_l <= 1'b0;
        win_r <= 1'b0;
        clear <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (push) begin
              clear <= 1'b1;
              pos   <= next_pos;
              if (tie) begin
                state <= S_HOLD;
              end else if (next_pos == POS_MAX) begin
                state <= S_WIN;
                win_r <= 1'b1;
              end else if (next_pos == POS_MIN) begin
                state <= S_WIN;
                win_l <= 1'b1;
              end else begin
                state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (hold_done) begin
              state <= S_IDLE;
            end
          end
          S_WIN: begin
            clear <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign leds = pos_leds(pos);

`ifdef TOW_REFEREE_SCORE_EN
  logic [3:0] score_l_q;
  logic [3:0] score_r_q;
  logic       enter_win_l;
  logic       enter_win_r;

  assign enter_win_l = take_push && !tie && (next_pos == POS_MIN);
  assign enter_win_r = take_push && !tie && (next_pos == POS_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
    end else begin
      if (enter_win_l && score_l_q != 4'd15) begin
        score_l_q <= score_l_q + 4'd1;
      end
      if (enter_win_r && score_r_q != 4'd15) begin
        score_r_q <= score_r_q + 4'd1;
      end
    end
  end

  assign score_l = score_l_q;
  assign score_r = score_r_q;
`else
  assign score_l = 4'd0;
  assign score_r = 4'd0;
`endif

endmodule

// File: tb/tb_tow_referee.sv
// Bench for tow_referee: directed scenarios plus random stimulus against a
// cycle-count model (press accepted only once the holdoff window has elapsed).
module tb_tow_referee;

  localparam int HO = 16;
`ifdef TOW_REFEREE_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       tie = 1'b0;
  logic       right = 1'b0;
  logic       new_game = 1'b0;
  logic       clear;
  logic [6:0] leds;
  logic       win_l;
  logic       win_r;
  logic [3:0] score_l;
  logic [3:0] score_r;

  int checks = 0;
  int errors = 0;

  // reference model state
  int cyc = 0;
  int m_pos = 3;
  int m_win = 0;     // 0 none, 1 left, 2 right
  int m_clr = 0;
  int m_ready = 0;   // first edge at which a press may be accepted
  int m_sl = 0;
  int m_sr = 0;

  always #5 clk = ~clk;

  tow_referee #(.HOLDOFF(HO)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .tie      (tie),
    .right    (right),
    .new_game (new_game),
    .clear    (clear),
    .leds     (leds),
    .win_l    (win_l),
    .win_r    (win_r),
    .score_l  (score_l),
    .score_r  (score_r)
  );

  task automatic model_step(input logic p, input logic t, input logic r,
                            input logic ng, input logic rs);
    cyc++;
    if (!rs) begin
      m_pos = 3; m_win = 0; m_clr = 0; m_ready = cyc + 1; m_sl = 0; m_sr = 0;
    end else if (ng) begin
      m_pos = 3; m_win = 0; m_clr = 1; m_ready = cyc + HO + 1;
    end else if (m_win != 0) begin
      m_clr = 1;
    end else if (p && cyc >= m_ready) begin
      m_clr = 1;
      m_ready = cyc + HO + 1;
      if (!t) begin
        m_pos = r ? m_pos + 1 : m_pos - 1;
        if (m_pos == 6) begin
          m_win = 2;
          if (SCORE_EN && m_sr < 15) m_sr++;
        end else if (m_pos == 0) begin
          m_win = 1;
          if (SCORE_EN && m_sl < 15) m_sl++;
        end
      end
    end else begin
      m_clr = 0;
    end
  endtask

  task automatic tick(input logic p, input logic t, input logic r,
                      input logic ng, input logic rs);
    push = p; tie = t; right = r; new_game = ng; rst = rs;
    @(posedge clk);
    model_step(p, t, r, ng, rs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (leds !== 7'b0001000) begin errors++; $display("FAIL reset_leds got %b want 0001000", leds); end
    checks++;
    if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", clear); end
    checks++;
    if ({win_l, win_r} !== 2'b00) begin errors++; $display("FAIL reset_win got %b want 00", {win_l, win_r}); end
    checks++;
    if ({score_l, score_r} !== 8'h00) begin errors++; $display("FAIL reset_score got %h want 00", {score_l, score_r}); end
  endtask

  task automatic test_right_push();
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (leds !== 7'b0010000 || clear !== 1'b1) begin
      errors++; $display("FAIL right_push leds %b clear %b want 0010000 1", leds, clear);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (clear !== 1'b0) begin errors++; $display("FAIL right_push_clear_pulse got %b want 0", clear); end
    for (int i = 2; i <= HO; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (leds !== 7'b0010000 || clear !== 1'b0) begin
        errors++; $display("FAIL holdoff_ignore cycle %0d leds %b clear %b want 0010000 0", i, leds, clear);
      end
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (leds !== 7'b0100000 || clear !== 1'b1) begin
      errors++; $display("FAIL holdoff_release leds %b clear %b want 0100000 1", leds, clear);
    end
  endtask

  task automatic test_tie();
    do_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (leds !== 7'b0001000 || clear !== 1'b1) begin
      errors++; $display("FAIL tie leds %b clear %b want 0001000 1", leds, clear);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (leds !== 7'b0001000 || clear !== 1'b0) begin
      errors++; $display("FAIL tie_hold leds %b clear %b want 0001000 0", leds, clear);
    end
  endtask

  task automatic test_right_win();
    logic [3:0] exp_sr;
    exp_sr = SCORE_EN ? 4'd1 : 4'd0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      if (k < 2) idle(HO);
    end
    checks++;
    if (leds !== 7'b1000000 || win_r !== 1'b1 || win_l !== 1'b0 || clear !== 1'b1) begin
      errors++; $display("FAIL right_win leds %b wl %b wr %b clr %b want 1000000 0 1 1", leds, win_l, win_r, clear);
    end
    checks++;
    if (score_r !== exp_sr) begin errors++; $display("FAIL right_win_score got %0d want %0d", score_r, exp_sr); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (leds !== 7'b1000000 || win_r !== 1'b1 || clear !== 1'b1) begin
        errors++; $display("FAIL win_frozen leds %b wr %b clr %b want 1000000 1 1", leds, win_r, clear);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (leds !== 7'b0001000 || win_r !== 1'b0 || clear !== 1'b1) begin
      errors++; $display("FAIL win_new_game leds %b wr %b clr %b want 0001000 0 1", leds, win_r, clear);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (leds !== 7'b0001000 || clear !== 1'b0 || score_r !== exp_sr) begin
      errors++; $display("FAIL new_game_hold leds %b clr %b score_r %0d want 0001000 0 %0d", leds, clear, score_r, exp_sr);
    end
  endtask

  task automatic test_new_game_push();
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (leds !== 7'b0001000 || clear !== 1'b1) begin
      errors++; $display("FAIL new_game_priority leds %b clr %b want 0001000 1", leds, clear);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (leds !== 7'b0001000 || clear !== 1'b0) begin
      errors++; $display("FAIL reset_dominates leds %b clr %b want 0001000 0", leds, clear);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (leds !== 7'b0010000 || clear !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset leds %b clr %b want 0010000 1", leds, clear);
    end
  endtask

  task automatic test_score_saturation();
    int exp_sl;
    do_reset();
    for (int w = 1; w <= 16; w++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(HO);
      for (int k = 0; k < 3; k++) begin
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        if (k < 2) idle(HO);
      end
      exp_sl = SCORE_EN ? ((w > 15) ? 15 : w) : 0;
      checks++;
      if (win_l !== 1'b1 || win_r !== 1'b0 || leds !== 7'b0000001 || score_l !== 4'(exp_sl)) begin
        errors++;
        $display("FAIL left_win %0d wl %b wr %b leds %b score_l %0d want 1 0 0000001 %0d", w, win_l, win_r, leds, score_l, exp_sl);
      end
    end
  endtask

  task automatic test_random();
    logic p, t, r, ng, rs;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 199) != 0);
      ng = ($urandom_range(0, 59) == 0);
      p  = ($urandom_range(0, 2) != 0);
      t  = ($urandom_range(0, 4) == 0);
      r  = 1'($urandom_range(0, 1));
      tick(p, t, r, ng, rs);
      checks++;
      if (leds !== 7'(1 << m_pos) || clear !== 1'(m_clr) || win_l !== (m_win == 1) ||
          win_r !== (m_win == 2) || score_l !== 4'(m_sl) || score_r !== 4'(m_sr) || (win_l && win_r)) begin
        errors++;
        $display("FAIL random cycle %0d leds %b clr %b wl %b wr %b sl %0d sr %0d want leds %b clr %0d win %0d sl %0d sr %0d",
                 i, leds, clear, win_l, win_r, score_l, score_r, 7'(1 << m_pos), m_clr, m_win, m_sl, m_sr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_push();
    test_tie();
    test_right_win();
    test_new_game_push();
    test_reset_mid_hold();
    test_score_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
